// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset CPU: FETCH -> DECODE -> EXEC -> WB/BR,
// with instruction-memory handshake, fetch timeout and sticky error reporting.
module multicycle_ctrl #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [5:0]       instr_op_i,
  input  logic             imem_ready_i,
  output logic             imem_req_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic [2:0]       alu_op_o,
  output logic             alu_src_o,
  output logic             reg_dst_o,
  output logic             reg_write_o,
  output logic             branch_o,
  output logic [2:0]       state_o,
  output logic [1:0]       err_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_BR     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Wait counter only needs to reach FETCH_TIMEOUT; one spare bit holds the incremented value.
  localparam int unsigned   WAIT_W     = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
  localparam logic [WAIT_W:0] WAIT_LIMIT = (WAIT_W + 1)'(FETCH_TIMEOUT);

  logic [2:0]        state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [1:0]        err_q, err_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W:0]   wait_inc;
  logic              timeout_hit;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTIU, OP_LUI: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_op_dec(input logic [5:0] op);
    case (op)
      OP_ADDI:  return 3'b010;
      OP_SLTIU: return 3'b111;
      OP_BEQ:   return 3'b011;
      OP_BNE:   return 3'b100;
      OP_LUI:   return 3'b101;
      default:  return 3'b000;
    endcase
  endfunction

  assign wait_inc    = {1'b0, wait_q} + (WAIT_W + 1)'(1);
  assign timeout_hit = (FETCH_TIMEOUT != 0) && (wait_inc == WAIT_LIMIT);

  // Next-state, op latch, error, wait-counter and retire-counter logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    // Cleared outside FETCH so every entry to FETCH starts counting from zero.
    wait_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready_i) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end else begin
          wait_d = wait_inc[WAIT_W-1:0];
        end
      end
      S_DECODE: begin
        op_d = instr_op_i;
        if (op_supported(instr_op_i)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end
      end
      S_EXEC: begin
        state_d = (op_q == OP_BEQ || op_q == OP_BNE) ? S_BR : S_WB;
      end
      S_WB, S_BR: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = run_i ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      err_q   <= ERR_NONE;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Phase strobes decoded from state and latched op; only ir_write_o sees an input.
  always_comb begin
    imem_req_o  = (state_q == S_FETCH);
    ir_write_o  = (state_q == S_FETCH) && imem_ready_i;
    pc_write_o  = (state_q == S_WB) || (state_q == S_BR);
    reg_write_o = (state_q == S_WB);
    branch_o    = (state_q == S_BR);
    halted_o    = (state_q == S_HALT);
    alu_op_o    = '0;
    alu_src_o   = 1'b0;
    reg_dst_o   = 1'b0;
    if (state_q == S_EXEC || state_q == S_WB || state_q == S_BR) begin
      alu_op_o  = alu_op_dec(op_q);
      alu_src_o = (op_q == OP_ADDI) || (op_q == OP_SLTIU) || (op_q == OP_LUI);
    end
    if (state_q == S_WB) begin
      reg_dst_o = (op_q == OP_RTYPE);
    end
  end

  assign state_o     = state_q;
  assign err_o       = err_q;
  assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected output vectors are
// queued as stimulus is driven and popped for comparison at the falling edge.
module tb_multicycle_ctrl;

  localparam logic [2:0] S_I = 3'd0, S_F = 3'd1, S_D = 3'd2, S_X = 3'd3,
                         S_W = 3'd4, S_B = 3'd5, S_H = 3'd6;
  localparam logic [5:0] OP_R = 6'b000000, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                         OP_ADDI = 6'b001000, OP_SLTIU = 6'b001011, OP_LUI = 6'b001111,
                         OP_BAD = 6'b100011;
  localparam logic ON = 1'b1, OFF = 1'b0;

  typedef struct packed {
    logic        chk;
    logic        rst;
    logic        run;
    logic        rdy;
    logic [5:0]  op;
    logic [15:0] exp;
  } row_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0, run_i = 1'b0, imem_ready_i = 1'b0;
  logic [5:0]  instr_op_i = '0;

  logic        req_a, irw_a, pcw_a, asrc_a, rdst_a, rw_a, br_a, halt_a;
  logic [2:0]  aop_a, st_a;
  logic [1:0]  err_a;
  logic [15:0] cnt_a;
  logic        req_b, irw_b, pcw_b, asrc_b, rdst_b, rw_b, br_b, halt_b;
  logic [2:0]  aop_b, st_b;
  logic [1:0]  err_b;
  logic [1:0]  cnt_b;
  logic [15:0] obs_a, obs_b;

  logic [15:0] sb[$];
  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .instr_op_i(instr_op_i),
    .imem_ready_i(imem_ready_i), .imem_req_o(req_a), .ir_write_o(irw_a),
    .pc_write_o(pcw_a), .alu_op_o(aop_a), .alu_src_o(asrc_a), .reg_dst_o(rdst_a),
    .reg_write_o(rw_a), .branch_o(br_a), .state_o(st_a), .err_o(err_a),
    .halted_o(halt_a), .instr_cnt_o(cnt_a)
  );

  multicycle_ctrl #(.CNT_W(2), .FETCH_TIMEOUT(4)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .instr_op_i(instr_op_i),
    .imem_ready_i(imem_ready_i), .imem_req_o(req_b), .ir_write_o(irw_b),
    .pc_write_o(pcw_b), .alu_op_o(aop_b), .alu_src_o(asrc_b), .reg_dst_o(rdst_b),
    .reg_write_o(rw_b), .branch_o(br_b), .state_o(st_b), .err_o(err_b),
    .halted_o(halt_b), .instr_cnt_o(cnt_b)
  );

  assign obs_a = {st_a, req_a, irw_a, pcw_a, aop_a, asrc_a, rdst_a, rw_a, br_a, err_a, halt_a};
  assign obs_b = {st_b, req_b, irw_b, pcw_b, aop_b, asrc_b, rdst_b, rw_b, br_b, err_b, halt_b};

  // Row = inputs for one cycle plus the outputs expected in that same cycle.
  function automatic row_t R(input logic chk, input logic rst, input logic run, input logic rdy,
                             input logic [5:0] op, input logic [2:0] st, input logic [2:0] aop,
                             input logic asrc, input logic rdst, input logic [1:0] err);
    row_t r;
    r.chk = chk; r.rst = rst; r.run = run; r.rdy = rdy; r.op = op;
    r.exp = {st, st == S_F, (st == S_F) && rdy, (st == S_W) || (st == S_B), aop, asrc, rdst,
             st == S_W, st == S_B, err, st == S_H};
    return r;
  endfunction

  task automatic drive(input row_t r);
    @(posedge clk_i);
    #1;
    rst_i = r.rst; run_i = r.run; imem_ready_i = r.rdy; instr_op_i = r.op;
    sb.push_back(r.exp);
  endtask

  task automatic test_reset;
    row_t rows[$];
    logic [15:0] want;
    rows.push_back(R(OFF, ON, ON, ON, OP_R, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, OFF, OFF, OP_R, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, OFF, ON, OP_R, S_I, 3'b000, OFF, OFF, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk_i);
      want = sb.pop_front();
      if (rows[i].chk) begin
        total++;
        if (obs_a !== want) begin bad++; $display("FAIL reset row%0d got=%h want=%h", i, obs_a, want); end
        total++;
        if (cnt_a !== 16'd0) begin bad++; $display("FAIL reset_cnt row%0d got=%0d want=0", i, cnt_a); end
      end
    end
  endtask

  task automatic test_rtype;
    row_t rows[$];
    logic [15:0] want;
    rows.push_back(R(OFF, ON, OFF, OFF, OP_R, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_R, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_R, S_F, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_R, S_D, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_R, S_X, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_R, S_W, 3'b000, OFF, ON, 2'b00));
    rows.push_back(R(ON, OFF, ON, OFF, OP_R, S_F, 3'b000, OFF, OFF, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk_i);
      want = sb.pop_front();
      if (rows[i].chk) begin
        total++;
        if (obs_a !== want) begin bad++; $display("FAIL rtype row%0d got=%h want=%h", i, obs_a, want); end
      end
    end
    total++;
    if (cnt_a !== 16'd1) begin bad++; $display("FAIL rtype_cnt got=%0d want=1", cnt_a); end
  endtask

  task automatic test_addi_wait;
    row_t rows[$];
    logic [15:0] want;
    rows.push_back(R(OFF, ON, OFF, OFF, OP_ADDI, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, OFF, OP_ADDI, S_I, 3'b000, OFF, OFF, 2'b00));
    repeat (3) rows.push_back(R(ON, OFF, ON, OFF, OP_ADDI, S_F, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_ADDI, S_F, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, OFF, OP_ADDI, S_D, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, OFF, OP_ADDI, S_X, 3'b010, ON, OFF, 2'b00));
    rows.push_back(R(ON, OFF, OFF, OFF, OP_ADDI, S_W, 3'b010, ON, OFF, 2'b00));
    rows.push_back(R(ON, OFF, OFF, OFF, OP_ADDI, S_I, 3'b000, OFF, OFF, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk_i);
      want = sb.pop_front();
      if (rows[i].chk) begin
        total++;
        if (obs_a !== want) begin bad++; $display("FAIL addi_wait row%0d got=%h want=%h", i, obs_a, want); end
      end
    end
    total++;
    if (cnt_a !== 16'd1) begin bad++; $display("FAIL addi_cnt got=%0d want=1", cnt_a); end
  endtask

  task automatic test_bne;
    row_t rows[$];
    logic [15:0] want;
    rows.push_back(R(OFF, ON, OFF, OFF, OP_BNE, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_BNE, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_BNE, S_F, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_BNE, S_D, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, OFF, ON, OP_BNE, S_X, 3'b100, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, OFF, ON, OP_BNE, S_B, 3'b100, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, OFF, ON, OP_BNE, S_I, 3'b000, OFF, OFF, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk_i);
      want = sb.pop_front();
      if (rows[i].chk) begin
        total++;
        if (obs_a !== want) begin bad++; $display("FAIL bne row%0d got=%h want=%h", i, obs_a, want); end
      end
    end
    total++;
    if (cnt_a !== 16'd1) begin bad++; $display("FAIL bne_cnt got=%0d want=1", cnt_a); end
  endtask

  task automatic test_back_to_back;
    row_t rows[$];
    logic [15:0] want;
    rows.push_back(R(OFF, ON, OFF, OFF, OP_SLTIU, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_SLTIU, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_SLTIU, S_F, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_SLTIU, S_D, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_BEQ, S_X, 3'b111, ON, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_BEQ, S_W, 3'b111, ON, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_BEQ, S_F, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_BEQ, S_D, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_R, S_X, 3'b011, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, OFF, ON, OP_R, S_B, 3'b011, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, OFF, ON, OP_R, S_I, 3'b000, OFF, OFF, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk_i);
      want = sb.pop_front();
      if (rows[i].chk) begin
        total++;
        if (obs_a !== want) begin bad++; $display("FAIL back_to_back row%0d got=%h want=%h", i, obs_a, want); end
      end
    end
    total++;
    if (cnt_a !== 16'd2) begin bad++; $display("FAIL back_to_back_cnt got=%0d want=2", cnt_a); end
  endtask

  task automatic test_illegal;
    row_t rows[$];
    logic [15:0] want;
    rows.push_back(R(OFF, ON, OFF, OFF, OP_BAD, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_BAD, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_BAD, S_F, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_BAD, S_D, 3'b000, OFF, OFF, 2'b00));
    repeat (20) rows.push_back(R(ON, OFF, ON, ON, OP_R, S_H, 3'b000, OFF, OFF, 2'b01));
    rows.push_back(R(ON, ON, ON, ON, OP_R, S_H, 3'b000, OFF, OFF, 2'b01));
    rows.push_back(R(ON, OFF, OFF, OFF, OP_R, S_I, 3'b000, OFF, OFF, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk_i);
      want = sb.pop_front();
      if (rows[i].chk) begin
        total++;
        if (obs_a !== want) begin bad++; $display("FAIL illegal row%0d got=%h want=%h", i, obs_a, want); end
      end
    end
    total++;
    if (cnt_a !== 16'd0) begin bad++; $display("FAIL illegal_cnt got=%0d want=0", cnt_a); end
  endtask

  task automatic test_timeout_default;
    row_t rows[$];
    logic [15:0] want;
    rows.push_back(R(OFF, ON, OFF, OFF, OP_R, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, OFF, OP_R, S_I, 3'b000, OFF, OFF, 2'b00));
    repeat (15) rows.push_back(R(ON, OFF, ON, OFF, OP_R, S_F, 3'b000, OFF, OFF, 2'b00));
    repeat (2) rows.push_back(R(ON, OFF, ON, ON, OP_R, S_H, 3'b000, OFF, OFF, 2'b10));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk_i);
      want = sb.pop_front();
      if (rows[i].chk) begin
        total++;
        if (obs_a !== want) begin bad++; $display("FAIL timeout15 row%0d got=%h want=%h", i, obs_a, want); end
      end
    end
  endtask

  task automatic test_timeout_short;
    row_t rows[$];
    logic [15:0] want;
    rows.push_back(R(OFF, ON, OFF, OFF, OP_R, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, OFF, OP_R, S_I, 3'b000, OFF, OFF, 2'b00));
    repeat (4) rows.push_back(R(ON, OFF, ON, OFF, OP_R, S_F, 3'b000, OFF, OFF, 2'b00));
    repeat (2) rows.push_back(R(ON, OFF, ON, OFF, OP_R, S_H, 3'b000, OFF, OFF, 2'b10));
    rows.push_back(R(ON, ON, ON, OFF, OP_R, S_H, 3'b000, OFF, OFF, 2'b10));
    rows.push_back(R(ON, OFF, ON, OFF, OP_R, S_I, 3'b000, OFF, OFF, 2'b00));
    repeat (3) rows.push_back(R(ON, OFF, ON, OFF, OP_R, S_F, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_R, S_F, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_R, S_D, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_R, S_X, 3'b000, OFF, OFF, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk_i);
      want = sb.pop_front();
      if (rows[i].chk) begin
        total++;
        if (obs_b !== want) begin bad++; $display("FAIL timeout4 row%0d got=%h want=%h", i, obs_b, want); end
      end
    end
  endtask

  task automatic test_lui_reset;
    row_t rows[$];
    logic [15:0] want;
    logic [15:0] want_cnt;
    rows.push_back(R(OFF, ON, OFF, OFF, OP_LUI, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_LUI, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_LUI, S_F, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_LUI, S_D, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, OFF, ON, OP_LUI, S_X, 3'b101, ON, OFF, 2'b00));
    rows.push_back(R(ON, OFF, OFF, ON, OP_LUI, S_W, 3'b101, ON, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_LUI, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_LUI, S_F, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_LUI, S_D, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, ON, ON, ON, OP_LUI, S_X, 3'b101, ON, OFF, 2'b00));
    rows.push_back(R(ON, OFF, OFF, OFF, OP_LUI, S_I, 3'b000, OFF, OFF, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk_i);
      want = sb.pop_front();
      if (rows[i].chk) begin
        total++;
        if (obs_a !== want) begin bad++; $display("FAIL lui_reset row%0d got=%h want=%h", i, obs_a, want); end
      end
      if (i == 6 || i == 10) begin
        want_cnt = (i == 6) ? 16'd1 : 16'd0;
        total++;
        if (cnt_a !== want_cnt) begin bad++; $display("FAIL lui_cnt row%0d got=%0d want=%0d", i, cnt_a, want_cnt); end
      end
    end
  endtask

  task automatic test_wrap;
    row_t rows[$];
    logic [15:0] want;
    int unsigned exp_cnt;
    logic [1:0] want_cnt;
    rows.push_back(R(OFF, ON, OFF, OFF, OP_R, S_I, 3'b000, OFF, OFF, 2'b00));
    rows.push_back(R(ON, OFF, ON, ON, OP_R, S_I, 3'b000, OFF, OFF, 2'b00));
    for (int k = 0; k < 4; k++) begin
      rows.push_back(R(ON, OFF, ON, ON, OP_R, S_F, 3'b000, OFF, OFF, 2'b00));
      rows.push_back(R(ON, OFF, ON, ON, OP_R, S_D, 3'b000, OFF, OFF, 2'b00));
      rows.push_back(R(ON, OFF, ON, ON, OP_R, S_X, 3'b000, OFF, OFF, 2'b00));
      rows.push_back(R(ON, OFF, (k < 3) ? ON : OFF, ON, OP_R, S_W, 3'b000, OFF, ON, 2'b00));
    end
    rows.push_back(R(ON, OFF, OFF, ON, OP_R, S_I, 3'b000, OFF, OFF, 2'b00));
    exp_cnt = 0;
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk_i);
      want = sb.pop_front();
      if (rows[i].chk) begin
        total++;
        if (obs_b !== want) begin bad++; $display("FAIL wrap row%0d got=%h want=%h", i, obs_b, want); end
        want_cnt = exp_cnt[1:0];
        total++;
        if (cnt_b !== want_cnt) begin bad++; $display("FAIL wrap_cnt row%0d got=%0d want=%0d", i, cnt_b, want_cnt); end
      end
      if (want[15:13] == S_W || want[15:13] == S_B) exp_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_addi_wait();
    test_bne();
    test_back_to_back();
    test_illegal();
    test_timeout_default();
    test_timeout_short();
    test_lui_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
